reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4: number of ordered reset domains, legal range 1..8.
REQ-002 Parameter SETTLE_CYCLES, default 30'd1000: consecutive locked cycles required before the first release, legal range 1..2^CNT_W-1.
REQ-003 Parameter STAGE_GAP, default 30'd500: cycles between successive stage releases, legal range 1..2^CNT_W-1.
REQ-004 Parameter CNT_W, default 30: width of the cycle counter.
REQ-005 clk_in  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 pll_locked  input  1  clock-source lock; asynchronous to clk_in.
REQ-008 sw_rst_req  input  1  synchronous single-cycle request to rerun the sequence.
REQ-009 rst_out  output  NUM_STAGES  active-high resets; bit 0 releases first.
REQ-010 seq_done  output  1  high when all stages are released.
REQ-011 seq_state  output  2  current state: WAIT_LOCK=0, SETTLE=1, RELEASE=2, DONE=3.

Function
REQ-012 pll_locked SHALL pass through a two-flop synchronizer; locked_sync is the second flop's output, and the FSM uses only locked_sync.
REQ-013 WAIT_LOCK: all rst_out=1, counter=0; the first edge sampling locked_sync=1 SHALL move to SETTLE with counter=0.
REQ-014 SETTLE: the counter SHALL increment every edge; the edge sampling counter==SETTLE_CYCLES-1 with locked_sync=1 SHALL enter RELEASE, clear rst_out[0], and set counter=0 and stage=0.
REQ-015 RELEASE: the counter SHALL increment every edge; the edge sampling counter==STAGE_GAP-1 SHALL clear rst_out[stage+1], increment stage and zero the counter.
REQ-016 The edge that clears rst_out[NUM_STAGES-1] SHALL enter DONE and set seq_done=1 on that same edge; when NUM_STAGES=1, that is the SETTLE exit edge.
REQ-017 Released bits SHALL stay 0 until an abort, so rst_out is always a contiguous run of zeros from bit 0.
REQ-018 Abort: in SETTLE, RELEASE or DONE, an edge sampling locked_sync=0 or sw_rst_req=1 SHALL set all rst_out=1, seq_done=0, counter=0, stage=0 and state WAIT_LOCK on that edge.
REQ-019 Abort SHALL take priority over every counter-driven transition on the same edge.
REQ-020 In WAIT_LOCK, sw_rst_req SHALL have no effect.
REQ-021 The counter SHALL never exceed the active terminal value, with no wrap.
REQ-022 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-023 While rst=1, the block SHALL immediately, without a clock, force rst_out all 1, seq_done=0, seq_state=WAIT_LOCK, counter=0, stage=0 and both synchronizer flops to 0.
REQ-024 After rst deasserts, the sequence SHALL restart from WAIT_LOCK regardless of pll_locked history.
REQ-025 Asserting rst mid-sequence SHALL reassert all rst_out at once.

Structure
REQ-026 Package reset_seq_pkg SHALL hold the 2-bit state encoding and the default values of CNT_W, SETTLE_CYCLES and STAGE_GAP.
REQ-027 The synchronizer SHALL be the sub-module sync_2ff, which is 1 bit wide, reset to 0 by rst, and instanced once.
REQ-028 The rest of the block SHALL be one FSM with one counter and one stage index of width clog2(NUM_STAGES)+1.

Verification (bench: SETTLE_CYCLES=8, STAGE_GAP=4, NUM_STAGES=4; edge 1 is the first edge with pll_locked=1)
REQ-029 pll_locked rises -> SETTLE at edge 3, rst_out=4'b1110 at edge 11, 4'b1100 at edge 15, 4'b1000 at edge 19, and 4'b0000 with seq_done=1 and seq_state=3 at edge 23.
REQ-030 pll_locked drops for one cycle at edge 8 (in SETTLE) -> WAIT_LOCK at edge 10, and the release timeline restarts from re-lock with no early release.
REQ-031 In DONE, pll_locked drops at edge n -> rst_out=4'b1111 and seq_done=0 at edge n+2, and the full sequence reruns after re-lock.
REQ-032 sw_rst_req pulse on the edge where counter==3 in RELEASE with stage=1 -> all rst_out=1 and state WAIT_LOCK that edge, with no rst_out[2] release.
REQ-033 rst asserted between edges mid-RELEASE -> rst_out=4'b1111 before the next edge; after release with pll_locked=1, rst_out[0] clears at the 11th edge.
REQ-034 Throughout every scenario, an assertion SHALL check that rst_out is always a contiguous run of zeros from bit 0 and that seq_done equals (rst_out==0).

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared state encoding and default timing constants for the reset sequencer.
package reset_seq_pkg;

  localparam int unsigned CNT_W_DEF         = 30;
  localparam logic [29:0] SETTLE_CYCLES_DEF = 30'd1000;
  localparam logic [29:0] STAGE_GAP_DEF     = 30'd500;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_SETTLE    = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops clear on rst_i.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      q_o    <= '0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset-release sequencer: waits for a settled PLL lock, then releases
// reset domains one by one, bit 0 first, with a fixed gap between stages.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned          NUM_STAGES    = 4,
  parameter int unsigned          CNT_W         = CNT_W_DEF,
  parameter logic [CNT_W-1:0]     SETTLE_CYCLES = CNT_W'(SETTLE_CYCLES_DEF),
  parameter logic [CNT_W-1:0]     STAGE_GAP     = CNT_W'(STAGE_GAP_DEF)
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  seq_done,
  output logic [1:0]            seq_state
);

  localparam int unsigned      STG_W       = $clog2(NUM_STAGES) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = SETTLE_CYCLES - CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LAST    = STAGE_GAP - CNT_W'(1);
  localparam logic [STG_W-1:0] STAGE_LAST  = STG_W'(NUM_STAGES - 1);

  logic                  locked_sync;
  logic                  abort;
  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [STG_W-1:0]      stage_q, stage_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  done_q, done_d;

  sync_2ff u_lock_sync (
    .clk_i (clk_in),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (locked_sync)
  );

  assign abort = !locked_sync || sw_rst_req;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;

    if (state_q != ST_WAIT_LOCK && abort) begin
      state_d   = ST_WAIT_LOCK;
      cnt_d     = '0;
      stage_d   = '0;
      rst_out_d = '1;
      done_d    = 1'b0;
    end else begin
      // Released bits always form a run of zeros from bit 0, so shifting left
      // by one releases exactly the next stage.
      case (state_q)
        ST_WAIT_LOCK: begin
          cnt_d     = '0;
          stage_d   = '0;
          rst_out_d = '1;
          done_d    = 1'b0;
          if (locked_sync) state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d     = '0;
            stage_d   = '0;
            rst_out_d = rst_out_q << 1;
            if (NUM_STAGES == 1) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d     = '0;
            stage_d   = stage_q + STG_W'(1);
            rst_out_d = rst_out_q << 1;
            if (stage_q + STG_W'(1) == STAGE_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= ST_WAIT_LOCK;
      cnt_q     <= '0;
      stage_q   <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign seq_done  = done_q;
  assign seq_state = state_q;

endmodule
